// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared definitions for the execute stage: exec opcode
//                encoding, zero constants and divider FSM state codes.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_stage_pkg;

  // Exec opcodes decoded upstream and carried in the ID/EX register.
  typedef enum logic [4:0] {
    EX_NOP    = 5'd0,
    EX_ADD    = 5'd1,
    EX_SUB    = 5'd2,
    EX_SLL    = 5'd3,
    EX_SLT    = 5'd4,
    EX_SLTU   = 5'd5,
    EX_XOR    = 5'd6,
    EX_SRL    = 5'd7,
    EX_SRA    = 5'd8,
    EX_OR     = 5'd9,
    EX_AND    = 5'd10,
    EX_LUI    = 5'd11,
    EX_AUIPC  = 5'd12,
    EX_JAL    = 5'd13,
    EX_JALR   = 5'd14,
    EX_BEQ    = 5'd15,
    EX_BNE    = 5'd16,
    EX_BLT    = 5'd17,
    EX_BGE    = 5'd18,
    EX_BLTU   = 5'd19,
    EX_BGEU   = 5'd20,
    EX_LOAD   = 5'd21,
    EX_STORE  = 5'd22,
    EX_MUL    = 5'd23,
    EX_MULH   = 5'd24,
    EX_MULHSU = 5'd25,
    EX_MULHU  = 5'd26,
    EX_DIV    = 5'd27,
    EX_DIVU   = 5'd28,
    EX_REM    = 5'd29,
    EX_REMU   = 5'd30
  } exec_e;

  localparam logic [31:0] c_zero32 = 32'h0000_0000;
  localparam logic [4:0]  c_zero5  = 5'd0;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_divider.sv
`default_nettype none
// ============================================================================
//  Module      : ex_divider
//  Description : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//                Works on magnitudes and applies the sign fix at the end.
//                Divide-by-zero and signed overflow skip the iterations.
//  Ports       : start     - divide op present (sampled only in IDLE)
//                is_signed - DIV/REM semantics
//                want_rem  - return remainder instead of quotient
//                a, b      - dividend, divisor
//                hold      - keep the finished result while high
//                busy      - stall request while a division is in flight
//                done      - result valid
//                result    - sign-corrected quotient or remainder
//  Revision    : 1.0  initial release
// ============================================================================
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        want_rem,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_q;      // dividend shifts out as quotient shifts in
  logic [31:0]      r_r;      // partial remainder
  logic [31:0]      r_den;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_want_rem;

  logic        w_div_zero;
  logic        w_overflow;
  logic        w_special;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_div_zero = (b == c_zero32);
  assign w_overflow = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_overflow;
  assign w_mag_a    = (is_signed && a[31]) ? (c_zero32 - a) : a;
  assign w_mag_b    = (is_signed && b[31]) ? (c_zero32 - b) : b;

  // One restoring step: bring in the next dividend bit, subtract when it fits.
  // The partial remainder is always below the divisor, so 33 bits suffice.
  assign w_shift = {r_r, r_q[31]};
  assign w_diff  = w_shift - {1'b0, r_den};

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (start) w_next = w_special ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (r_cnt == CNT_W'(1)) w_next = DIV_DONE;
      DIV_DONE: if (!hold) w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_q        <= c_zero32;
      r_r        <= c_zero32;
      r_den      <= c_zero32;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_want_rem <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_want_rem <= want_rem;
            r_cnt      <= '0;
            if (w_div_zero) begin
              // Final values stored directly; sign fix disabled.
              r_q     <= 32'hFFFF_FFFF;
              r_r     <= a;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_overflow) begin
              r_q     <= 32'h8000_0000;
              r_r     <= c_zero32;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_q     <= w_mag_a;
              r_r     <= c_zero32;
              r_den   <= w_mag_b;
              r_neg_q <= is_signed && (a[31] ^ b[31]);
              r_neg_r <= is_signed && a[31];
              r_cnt   <= CNT_W'(DIV_ITERS);
            end
          end
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (!w_diff[32]) begin
            r_r <= w_diff[31:0];
            r_q <= {r_q[30:0], 1'b1};
          end else begin
            r_r <= w_shift[31:0];
            r_q <= {r_q[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign w_q_fix = r_neg_q ? (c_zero32 - r_q) : r_q;
  assign w_r_fix = r_neg_r ? (c_zero32 - r_r) : r_r;

  assign busy   = ((r_state == DIV_IDLE) && start) || (r_state == DIV_BUSY);
  assign done   = (r_state == DIV_DONE);
  assign result = r_want_rem ? w_r_fix : w_q_fix;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the RV32IM pipeline. Combinational ALU,
//                multiplier, branch resolution and address generation, plus
//                an iterative divider that requests a pipeline stall.
//  Ports       : clk, rst (sync, active-high), stall_hold (downstream stall)
//                exec/funct3/rdest/rs1/rs2/imm/addr/we/mux from ID/EX
//                ex_* writeback, mem_* memory request, branch_* redirect,
//                stall_req_out to the stall controller
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_hold,
  input  logic [4:0]  exec_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rdest_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] addr_in,
  input  logic        we_in,
  input  logic        mux_in,
  output logic [4:0]  ex_rdest_out,
  output logic [31:0] ex_wdata_out,
  output logic        ex_we_out,
  output logic        mem_re_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [2:0]  mem_funct3_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out,
  output logic        stall_req_out
);

  exec_e       w_op;
  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic [31:0] w_agen;
  logic [31:0] w_pc_imm;
  logic [31:0] w_pc_4;
  logic [32:0] w_mul_a;
  logic [32:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_div_op;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_div_result;

  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_re;
  logic        w_mwe;
  logic        w_taken;
  logic [31:0] w_target;

  assign w_op     = exec_e'(exec_in);
  assign w_op2    = mux_in ? imm_in : rs2_in;
  assign w_shamt  = w_op2[4:0];
  assign w_agen   = rs1_in + imm_in;
  assign w_pc_imm = addr_in + imm_in;
  assign w_pc_4   = addr_in + 32'd4;

  // A single 33x33 signed multiplier covers all four MUL variants: the
  // extra top bit is the sign for signed operands and zero otherwise.
  assign w_mul_a = {((w_op == EX_MULH) || (w_op == EX_MULHSU)) && rs1_in[31], rs1_in};
  assign w_mul_b = {(w_op == EX_MULH) && w_op2[31], w_op2};
  assign w_prod  = $signed(w_mul_a) * $signed(w_mul_b);

  assign w_div_op = (w_op == EX_DIV) || (w_op == EX_DIVU) ||
                    (w_op == EX_REM) || (w_op == EX_REMU);

  ex_divider #(
    .DIV_ITERS (DIV_ITERS)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_op),
    .is_signed ((w_op == EX_DIV) || (w_op == EX_REM)),
    .want_rem  ((w_op == EX_REM) || (w_op == EX_REMU)),
    .a         (rs1_in),
    .b         (w_op2),
    .hold      (stall_hold),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .result    (w_div_result)
  );

  always_comb begin
    w_wdata  = c_zero32;
    w_we     = we_in;
    w_re     = 1'b0;
    w_mwe    = 1'b0;
    w_taken  = 1'b0;
    w_target = c_zero32;
    case (w_op)
      EX_ADD:    w_wdata = rs1_in + w_op2;
      EX_SUB:    w_wdata = rs1_in - w_op2;
      EX_SLL:    w_wdata = rs1_in << w_shamt;
      EX_SLT:    w_wdata = {31'd0, $signed(rs1_in) < $signed(w_op2)};
      EX_SLTU:   w_wdata = {31'd0, rs1_in < w_op2};
      EX_XOR:    w_wdata = rs1_in ^ w_op2;
      EX_SRL:    w_wdata = rs1_in >> w_shamt;
      EX_SRA:    w_wdata = $signed(rs1_in) >>> w_shamt;
      EX_OR:     w_wdata = rs1_in | w_op2;
      EX_AND:    w_wdata = rs1_in & w_op2;
      EX_LUI:    w_wdata = imm_in;
      EX_AUIPC:  w_wdata = w_pc_imm;
      EX_JAL: begin
        w_wdata  = w_pc_4;
        w_taken  = 1'b1;
        w_target = w_pc_imm;
      end
      EX_JALR: begin
        w_wdata  = w_pc_4;
        w_taken  = 1'b1;
        w_target = w_agen & 32'hFFFF_FFFE;
      end
      EX_BEQ, EX_BNE, EX_BLT, EX_BGE, EX_BLTU, EX_BGEU: begin
        w_we     = 1'b0;
        w_target = w_pc_imm;
        case (w_op)
          EX_BEQ:  w_taken = (rs1_in == rs2_in);
          EX_BNE:  w_taken = (rs1_in != rs2_in);
          EX_BLT:  w_taken = ($signed(rs1_in) <  $signed(rs2_in));
          EX_BGE:  w_taken = ($signed(rs1_in) >= $signed(rs2_in));
          EX_BLTU: w_taken = (rs1_in <  rs2_in);
          default: w_taken = (rs1_in >= rs2_in);
        endcase
      end
      EX_LOAD:   w_re = 1'b1;
      EX_STORE: begin
        w_mwe = 1'b1;
        w_we  = 1'b0;
      end
      EX_MUL:    w_wdata = w_prod[31:0];
      EX_MULH, EX_MULHSU, EX_MULHU: w_wdata = w_prod[63:32];
      EX_DIV, EX_DIVU, EX_REM, EX_REMU:
                 w_wdata = w_div_done ? w_div_result : c_zero32;
      default:   w_we = 1'b0;   // NOP and unused encodings
    endcase
  end

  // Reset forces every output low, independent of the incoming bundle.
  assign ex_rdest_out      = rst ? c_zero5  : rdest_in;
  assign ex_wdata_out      = rst ? c_zero32 : w_wdata;
  assign ex_we_out         = rst ? 1'b0     : w_we;
  assign mem_re_out        = rst ? 1'b0     : w_re;
  assign mem_we_out        = rst ? 1'b0     : w_mwe;
  assign mem_addr_out      = rst ? c_zero32 : w_agen;
  assign mem_wdata_out     = rst ? c_zero32 : rs2_in;
  assign mem_funct3_out    = rst ? 3'd0     : funct3_in;
  assign branch_taken_out  = rst ? 1'b0     : w_taken;
  assign branch_target_out = rst ? c_zero32 : w_target;
  assign stall_req_out     = rst ? 1'b0     : w_div_busy;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Directed self-checking bench for ex_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_hold;
  logic [4:0]  exec_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rdest_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic [31:0] imm_in;
  logic [31:0] addr_in;
  logic        we_in;
  logic        mux_in;
  logic [4:0]  ex_rdest_out;
  logic [31:0] ex_wdata_out;
  logic        ex_we_out;
  logic        mem_re_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [2:0]  mem_funct3_out;
  logic        branch_taken_out;
  logic [31:0] branch_target_out;
  logic        stall_req_out;

  int passed;
  int failed;
  int total;
  int n;

  ex_stage #(.DIV_ITERS(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_hold        (stall_hold),
    .exec_in           (exec_in),
    .funct3_in         (funct3_in),
    .rdest_in          (rdest_in),
    .rs1_in            (rs1_in),
    .rs2_in            (rs2_in),
    .imm_in            (imm_in),
    .addr_in           (addr_in),
    .we_in             (we_in),
    .mux_in            (mux_in),
    .ex_rdest_out      (ex_rdest_out),
    .ex_wdata_out      (ex_wdata_out),
    .ex_we_out         (ex_we_out),
    .mem_re_out        (mem_re_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
    .mem_funct3_out    (mem_funct3_out),
    .branch_taken_out  (branch_taken_out),
    .branch_target_out (branch_target_out),
    .stall_req_out     (stall_req_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pc,
                       input logic mx, input logic wen);
    exec_in = op;
    rs1_in  = a;
    rs2_in  = b;
    imm_in  = im;
    addr_in = pc;
    mux_in  = mx;
    we_in   = wen;
  endtask

  // Step to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with stall_req high, starting in the cycle the op appears.
  task automatic wait_div(output int cnt);
    cnt = 0;
    while (stall_req_out && cnt < 60) begin
      cnt++;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst = 1'b1; stall_hold = 1'b0;
    funct3_in = 3'b010; rdest_in = 5'd3;
    drive(EX_DIV, 32'hFFFF_FFF9, 32'd2, 32'd4, 32'h40, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    // Reset with a live divide op on the inputs: everything low.
    chk("rst_wdata", ex_wdata_out, 32'h0);
    chk("rst_stall", {31'd0, stall_req_out}, 32'h0);
    chk("rst_any", {31'd0, |{ex_rdest_out, ex_we_out, mem_re_out, mem_we_out, mem_addr_out,
                              mem_wdata_out, mem_funct3_out, branch_taken_out,
                              branch_target_out}}, 32'h0);
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;

    cyc();
    drive(EX_ADD, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h0, 1'b1, 1'b1);
    #1;
    chk("add_wdata", ex_wdata_out, 32'h8000_0000);
    chk("add_we", {31'd0, ex_we_out}, 32'h1);
    chk("add_stall", {31'd0, stall_req_out}, 32'h0);
    chk("add_rdest", {27'd0, ex_rdest_out}, 32'd3);

    drive(EX_BLT, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 1'b0, 1'b1);
    #1;
    chk("blt_taken", {31'd0, branch_taken_out}, 32'h1);
    chk("blt_target", branch_target_out, 32'h120);
    chk("blt_we", {31'd0, ex_we_out}, 32'h0);
    drive(EX_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 1'b0, 1'b1);
    #1;
    chk("bltu_taken", {31'd0, branch_taken_out}, 32'h0);

    drive(EX_JALR, 32'h1003, 32'h0, 32'h0, 32'h40, 1'b1, 1'b1);
    #1;
    chk("jalr_target", branch_target_out, 32'h1002);
    chk("jalr_wdata", ex_wdata_out, 32'h44);
    chk("jalr_taken", {31'd0, branch_taken_out}, 32'h1);

    drive(EX_SRA, 32'h8000_0000, 32'h0, 32'h4, 32'h0, 1'b1, 1'b1);
    #1;
    chk("sra", ex_wdata_out, 32'hF800_0000);
    drive(EX_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("slt", ex_wdata_out, 32'h1);
    drive(EX_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("mulhu", ex_wdata_out, 32'hFFFF_FFFE);
    drive(EX_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("mulh", ex_wdata_out, 32'h0);
    drive(EX_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("mulhsu", ex_wdata_out, 32'hFFFF_FFFF);
    drive(EX_MUL, 32'h0001_0003, 32'h0001_0005, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("mul", ex_wdata_out, 32'h0008_000F);
    drive(EX_STORE, 32'h1000, 32'hDEAD, 32'h8, 32'h0, 1'b1, 1'b1);
    #1;
    chk("st_mwe", {31'd0, mem_we_out}, 32'h1);
    chk("st_we", {31'd0, ex_we_out}, 32'h0);
    chk("st_addr", mem_addr_out, 32'h1008);
    chk("st_wdata", mem_wdata_out, 32'hDEAD);
    drive(EX_LOAD, 32'h2000, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1);
    #1;
    chk("ld_re", {31'd0, mem_re_out}, 32'h1);
    chk("ld_addr", mem_addr_out, 32'h1FFC);
    drive(EX_NOP, 32'h5, 32'h6, 32'h7, 32'h8, 1'b0, 1'b1);
    #1;
    chk("nop_en", {29'd0, ex_we_out, mem_re_out, mem_we_out}, 32'h0);

    // Normal signed divide: -7 / 2.
    cyc();
    drive(EX_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("div_cycles", n, 32'd33);
    chk("div_result", ex_wdata_out, 32'hFFFF_FFFD);
    cyc();
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    cyc();
    drive(EX_REM, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("rem_cycles", n, 32'd33);
    chk("rem_result", ex_wdata_out, 32'hFFFF_FFFF);
    cyc();
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    cyc();
    drive(EX_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("divu_result", ex_wdata_out, 32'h0FFF_FFFF);
    cyc();
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Special cases finish in one cycle.
    cyc();
    drive(EX_DIVU, 32'd1234, 32'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("divz_cycles", n, 32'd1);
    chk("divz_result", ex_wdata_out, 32'hFFFF_FFFF);
    cyc();
    drive(EX_REMU, 32'd1234, 32'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("remz_result", ex_wdata_out, 32'd1234);
    cyc();
    drive(EX_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("ovf_cycles", n, 32'd1);
    chk("ovf_div", ex_wdata_out, 32'h8000_0000);
    cyc();
    drive(EX_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("ovf_rem", ex_wdata_out, 32'h0);
    cyc();
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Reset in the middle of a division.
    cyc();
    drive(EX_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_rst_stall", {31'd0, stall_req_out}, 32'h0);
    chk("mid_rst_wdata", ex_wdata_out, 32'h0);
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stall_req_out}, 32'h0);
    cyc();
    drive(EX_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("post_rst_cycles", n, 32'd33);
    chk("post_rst_result", ex_wdata_out, 32'd14);
    cyc();
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Result held in DONE while the downstream stage stalls.
    cyc();
    stall_hold = 1'b1;
    drive(EX_REMU, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    wait_div(n);
    chk("hold_cycles", n, 32'd33);
    chk("hold_result0", ex_wdata_out, 32'd2);
    repeat (3) @(posedge clk);
    #2;
    chk("hold_result3", ex_wdata_out, 32'd2);
    chk("hold_stall", {31'd0, stall_req_out}, 32'h0);
    stall_hold = 1'b0;
    cyc();
    drive(EX_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("hold_release", ex_wdata_out, 32'h0);
    cyc();
    chk("idle_stall", {31'd0, stall_req_out}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM core. Sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Combinational ALU, branch resolution and address generation for RV32I, plus single-cycle MUL*.
- Iterative radix-2 divider for DIV/DIVU/REM/REMU. It raises stall_req to the stall controller while busy.

Parameters:
- DIV_ITERS, 32, number of divider iterations. Must equal the data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall_hold  in  1  downstream stall (stall[3]). EX result must be held.
- exec_in  in  5  exec opcode (shared package encoding)
- funct3_in  in  3  load/store width and sign, passed through
- rdest_in  in  5  destination register
- rs1_in  in  32  operand 1 value
- rs2_in  in  32  operand 2 / store data
- imm_in  in  32  sign-extended immediate
- addr_in  in  32  instruction PC
- we_in  in  1  register write enable
- mux_in  in  1  1 = op2 is imm_in, 0 = op2 is rs2_in
- ex_rdest_out  out  5  destination register
- ex_wdata_out  out  32  writeback value
- ex_we_out  out  1  writeback enable
- mem_re_out  out  1  load request
- mem_we_out  out  1  store request
- mem_addr_out  out  32  rs1+imm
- mem_wdata_out  out  32  rs2_in
- mem_funct3_out  out  3  funct3_in passthrough
- branch_taken_out  out  1  redirect fetch
- branch_target_out  out  32  redirect PC
- stall_req_out  out  1  request stall of IF/ID/EX

Behaviour:
- Reset: all outputs are 0 while rst=1. Divider FSM goes to IDLE, counter 0, quotient/remainder 0. This applies mid-division too.
- Non-divide ops are purely combinational, same cycle as inputs. stall_req=0.
- ALU: op2 = mux_in ? imm_in : rs2_in.
  - ADD/SUB/AND/OR/XOR: 32-bit wraparound.
  - SLT/SLTU: signed/unsigned compare.
  - SLL/SRL/SRA: shift by op2[4:0].
  - LUI: imm. AUIPC: addr+imm.
- MUL: low 32 bits. MULH/MULHSU/MULHU: high 32 bits of the 64-bit signed×signed, signed×unsigned and unsigned×unsigned products.
- JAL: target = addr+imm, taken=1, wdata = addr+4.
- JALR: target = (rs1+imm) & ~1, taken=1, wdata = addr+4.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU compare rs1_in vs rs2_in.
  - taken=1 and target=addr+imm on true.
  - ex_we forced 0 for branches.
- LOAD: mem_re=1. STORE: mem_we=1, ex_we=0. mem_addr = rs1+imm for both.
- NOP: all enables 0.
- ex_rdest_out = rdest_in. ex_we_out = we_in, except where forced 0 above.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE & divide op: stall_req=1 combinationally.
    - Next state is BUSY with cnt=DIV_ITERS. Operands latched as magnitudes, result signs recorded.
    - Special case: divisor=0 or (signed, dividend=0x80000000, divisor=-1). Go straight to DONE with the spec result latched.
  - BUSY: one restoring shift-subtract step per cycle, cnt decrements. stall_req=1. Goes to DONE when cnt reaches 1.
  - DONE: stall_req=0 and ex_wdata = sign-corrected quotient or remainder.
    - Returns to IDLE when stall_hold=0.
    - Stays in DONE, holding the result, while stall_hold=1.
- Normal divide timing, cycle 0 = op first presented: stall_req high for cycles 0..32, result in cycle 33. Total latency 34 cycles.
- Special-case divide: stall_req high for cycle 0 only, result in cycle 1.
- Divide-by-zero results:
  - DIV/DIVU quotient = 0xFFFFFFFF. REM/REMU = dividend.
- Signed overflow results: DIV = 0x80000000, REM = 0.
- Remainder sign follows the dividend. Quotient is negative iff the operand signs differ and the divisor is nonzero.
- Back-to-back divides: the second op arrives in IDLE after DONE, then restarts normally.
- While in BUSY/DONE, operands are taken from latched state, not the inputs.

Decomposition:
- Shared package (define.v) holds:
  - exec codes, 5-bit. NOP=0, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LOAD, STORE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - zero32/zero5 constants.
  - FSM state codes.
- One sub-module: ex_divider. It owns the FSM, counter, special cases and sign fix. Its interface is start, signed, want_rem, a, b, hold → busy, done, result.

Test Plan:
- ADD mux=1, rs1=0x7FFFFFFF, imm=1 → wdata=0x80000000, we=1, stall_req=0 same cycle.
- BLT rs1=0xFFFFFFFF, rs2=1, addr=0x100, imm=0x20 → taken=1, target=0x120. Same inputs with BLTU → taken=0.
- JALR rs1=0x1003, imm=0, addr=0x40 → target=0x1002, wdata=0x44.
- DIV rs1=-7, rs2=2, inputs held → stall_req=1 for 33 cycles; cycle 33 wdata=0xFFFFFFFD. REM → 0xFFFFFFFF.
- DIVU rs2=0 → stall_req 1 cycle, wdata=0xFFFFFFFF. DIV 0x80000000/-1 → 0x80000000. REM of that pair → 0.
- rst asserted at cycle 10 of a DIV → next cycle all outputs 0, FSM IDLE. Later, DIV with stall_hold=1 at DONE → result held until hold drops.
